// File: rtl/assoc_dcache.sv
// assoc_dcache: 2-way set-associative, write-back, write-allocate data cache with 4-byte blocks and one LRU bit per set.
// Define DCACHE_STATS_EN to add saturating 16-bit hit_count / miss_count outputs.
module assoc_dcache #(
    parameter int ADDR_W   = 8,
    parameter int SET_BITS = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [7:0]        cpu_writeData,
    output logic [7:0]        cpu_readData,
    output logic              busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_address,
    output logic [31:0]       mem_writeData,
    input  logic [31:0]       mem_readData,
    input  logic              mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int TAG_W = ADDR_W - 2 - SET_BITS;
    localparam int SETS  = 1 << SET_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t                     state;
    logic [31:0]                data_mem [2][SETS];
    logic [TAG_W-1:0]           tag_mem  [2][SETS];
    logic [SETS-1:0][1:0]       valid_bits;
    logic [SETS-1:0][1:0]       dirty_bits;
    logic [SETS-1:0]            lru_bits;
    logic                       victim_q;
    logic [31:0]                fill_block;

    logic [1:0]                 offset;
    logic [SET_BITS-1:0]        set_idx;
    logic [TAG_W-1:0]           req_tag;
    logic [4:0]                 byte_lsb;
    logic                       access;
    logic                       hit0;
    logic                       hit1;
    logic                       hit;
    logic                       hit_way;
    logic                       victim_way;
    logic                       lookup_hit;
    logic [31:0]                hit_block;

    assign offset   = cpu_address[1:0];
    assign set_idx  = cpu_address[SET_BITS+1:2];
    assign req_tag  = cpu_address[ADDR_W-1:SET_BITS+2];
    assign byte_lsb = {offset, 3'b000};

    always_comb begin
        access       = read || write;
        hit0         = valid_bits[set_idx][0] && (tag_mem[0][set_idx] == req_tag);
        hit1         = valid_bits[set_idx][1] && (tag_mem[1][set_idx] == req_tag);
        hit          = hit0 || hit1;
        hit_way      = hit1;
        lookup_hit   = (state == IDLE) && access && hit;
        busywait     = (state != IDLE) || (access && !hit);
        hit_block    = data_mem[hit_way][set_idx];
        cpu_readData = hit_block[byte_lsb +: 8];
        if (!valid_bits[set_idx][0])
            victim_way = 1'b0;
        else if (!valid_bits[set_idx][1])
            victim_way = 1'b1;
        else
            victim_way = lru_bits[set_idx];
    end

    // Control state and memory-side strobes; address/data registers need no reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            valid_bits <= '0;
            dirty_bits <= '0;
            lru_bits   <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            victim_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (hit) begin
                            lru_bits[set_idx] <= ~hit_way;
                            if (write)
                                dirty_bits[set_idx][hit_way] <= 1'b1;
                        end else begin
                            victim_q <= victim_way;
                            if (dirty_bits[set_idx][victim_way]) begin
                                state         <= WRITEBACK;
                                mem_write     <= 1'b1;
                                mem_address   <= {tag_mem[victim_way][set_idx], set_idx};
                                mem_writeData <= data_mem[victim_way][set_idx];
                            end else begin
                                state       <= FETCH;
                                mem_read    <= 1'b1;
                                mem_address <= {req_tag, set_idx};
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state       <= FETCH;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= {req_tag, set_idx};
                    end
                end
                FETCH: begin
                    if (!mem_busywait) begin
                        state      <= UPDATE;
                        mem_read   <= 1'b0;
                        fill_block <= mem_readData;
                    end
                end
                UPDATE: begin
                    state                         <= IDLE;
                    valid_bits[set_idx][victim_q] <= 1'b1;
                    dirty_bits[set_idx][victim_q] <= 1'b0;
                    lru_bits[set_idx]             <= ~victim_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (lookup_hit && write) begin
                data_mem[hit_way][set_idx][byte_lsb +: 8] <= cpu_writeData;
            end else if (state == UPDATE) begin
                data_mem[victim_q][set_idx] <= fill_block;
                tag_mem[victim_q][set_idx]  <= req_tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // refill_pending marks the completion hit that follows a refill so it is not counted twice.
    logic refill_pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count      <= '0;
            miss_count     <= '0;
            refill_pending <= 1'b0;
        end else begin
            if (state == UPDATE)
                refill_pending <= 1'b1;
            else if ((state == IDLE) && access)
                refill_pending <= 1'b0;
            if (lookup_hit && !refill_pending && (hit_count != '1))
                hit_count <= hit_count + 16'd1;
            if ((state == IDLE) && access && !hit && (miss_count != '1))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_dcache.sv
// tb_assoc_dcache: directed and random accesses against a recency-ordered cache model with a latency-randomised memory.
// Counter outputs are checked when DCACHE_STATS_EN is defined for both files.
module tb_assoc_dcache;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  cpu_address = '0;
    logic [7:0]  cpu_writeData = '0;
    logic [7:0]  cpu_readData;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writeData;
    logic [31:0] mem_readData = '0;
    logic        mem_busywait = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    assoc_dcache #(.ADDR_W(8), .SET_BITS(2)) dut (
        .clock(clock),
        .reset(reset),
        .read(read),
        .write(write),
        .cpu_address(cpu_address),
        .cpu_writeData(cpu_writeData),
        .cpu_readData(cpu_readData),
        .busywait(busywait),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_writeData(mem_writeData),
        .mem_readData(mem_readData),
        .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Backing memory seen by the cache, with per-transfer latency.
    logic [31:0] mem_model [64];
    int fixed_lat = -1;
    int lat_target = 0;
    int lat_cnt = 0;

    function automatic int next_lat();
        return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    endfunction

    always @(negedge clock) begin
        if (mem_read || mem_write) begin
            if (lat_cnt < lat_target) begin
                mem_busywait = 1'b1;
                lat_cnt++;
            end else begin
                mem_busywait = 1'b0;
                if (mem_read)
                    mem_readData = mem_model[mem_address];
                else
                    mem_model[mem_address] = mem_writeData;
                lat_cnt = 0;
                lat_target = next_lat();
            end
        end else begin
            mem_busywait = 1'b0;
            lat_cnt = 0;
            lat_target = next_lat();
        end
    end

    int          wb_cnt = 0;
    int          fetch_cnt = 0;
    int          both_cnt = 0;
    logic [5:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [5:0]  fetch_addr = '0;

    always @(posedge clock) begin
        if (!reset) begin
            if (mem_write && !mem_busywait) begin
                wb_cnt++;
                wb_addr = mem_address;
                wb_data = mem_writeData;
            end
            if (mem_read && !mem_busywait) begin
                fetch_cnt++;
                fetch_addr = mem_address;
            end
        end
        if (mem_read && mem_write)
            both_cnt++;
    end

    // Reference model: per-set lines with last-use timestamps; the victim is the least recently used line.
    logic [3:0]  m_tag   [4][2];
    bit          m_valid [4][2];
    bit          m_dirty [4][2];
    logic [31:0] m_data  [4][2];
    int unsigned m_used  [4][2];
    int unsigned tick = 0;
    logic [31:0] ref_mem [64];
    int          m_hits = 0;
    int          m_misses = 0;

    task automatic model_reset();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_used[s][w]  = 0;
            end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic run_access(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                              input string name, output logic [7:0] rd_o, output bit hit_o);
        logic [1:0]  s;
        logic [1:0]  off;
        logic [3:0]  t;
        int          way;
        int          vict;
        bit          exp_hit;
        bit          exp_wb;
        logic [5:0]  exp_wb_addr;
        logic [31:0] exp_wb_data;
        logic [31:0] blk;
        logic [7:0]  exp_rd;
        int          wb0;
        int          f0;
        int          n;
        bit          first_busy;

        off = addr[1:0];
        s   = addr[3:2];
        t   = addr[7:4];
        way = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == t)
                way = w;
        exp_hit = (way >= 0);
        exp_wb = 1'b0;
        exp_wb_addr = '0;
        exp_wb_data = '0;
        if (!exp_hit) begin
            m_misses++;
            if (!m_valid[s][0])
                vict = 0;
            else if (!m_valid[s][1])
                vict = 1;
            else
                vict = (m_used[s][0] < m_used[s][1]) ? 0 : 1;
            if (m_valid[s][vict] && m_dirty[s][vict]) begin
                exp_wb = 1'b1;
                exp_wb_addr = {m_tag[s][vict], s};
                exp_wb_data = m_data[s][vict];
                ref_mem[exp_wb_addr] = exp_wb_data;
            end
            m_data[s][vict]  = ref_mem[{t, s}];
            m_tag[s][vict]   = t;
            m_valid[s][vict] = 1'b1;
            m_dirty[s][vict] = 1'b0;
            way = vict;
        end else begin
            m_hits++;
        end
        tick++;
        m_used[s][way] = tick;
        blk = m_data[s][way];
        exp_rd = blk[int'(off)*8 +: 8];
        if (wr) begin
            blk[int'(off)*8 +: 8] = wd;
            m_data[s][way] = blk;
            m_dirty[s][way] = 1'b1;
        end

        wb0 = wb_cnt;
        f0 = fetch_cnt;
        @(negedge clock);
        read = !wr;
        write = wr;
        cpu_address = addr;
        cpu_writeData = wd;
        #1;
        first_busy = busywait;
        n = 0;
        while (busywait === 1'b1 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        rd_o = cpu_readData;
        hit_o = !first_busy;
        check({name, "/done"}, {31'd0, busywait}, 32'd0);
        @(posedge clock);
        #1;
        read = 1'b0;
        write = 1'b0;

        check({name, "/hit"}, {31'd0, hit_o}, {31'd0, exp_hit});
        if (!wr)
            check({name, "/rdata"}, {24'd0, rd_o}, {24'd0, exp_rd});
        check({name, "/wb_count"}, wb_cnt - wb0, {31'd0, exp_wb});
        if (exp_wb) begin
            check({name, "/wb_addr"}, {26'd0, wb_addr}, {26'd0, exp_wb_addr});
            check({name, "/wb_data"}, wb_data, exp_wb_data);
        end
        check({name, "/fetch_count"}, fetch_cnt - f0, {31'd0, !exp_hit});
        if (!exp_hit)
            check({name, "/fetch_addr"}, {26'd0, fetch_addr}, {26'd0, t, s});
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        read = 1'b0;
        write = 1'b0;
        @(posedge clock);
        #1;
        check("reset/busywait", {31'd0, busywait}, 32'd0);
        check("reset/mem_read", {31'd0, mem_read}, 32'd0);
        check("reset/mem_write", {31'd0, mem_write}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        bit         h;
        int         wb_base;
        int         n;
        bit         wr;
        logic [7:0] addr;

        for (int i = 0; i < 64; i++)
            mem_model[i] = $urandom;
        mem_model[0] = 32'hDDCCBBAA;
        for (int i = 0; i < 64; i++)
            ref_mem[i] = mem_model[i];
        model_reset();

        @(posedge clock);
        @(posedge clock);
        #1;
        check("por/busywait", {31'd0, busywait}, 32'd0);
        check("por/mem_read", {31'd0, mem_read}, 32'd0);
        check("por/mem_write", {31'd0, mem_write}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        fixed_lat = 3;
        run_access(1'b0, 8'h00, 8'h00, "rd00_first", rd, h);
        check("rd00_first/fetch_addr_const", {26'd0, fetch_addr}, 32'h00);
        check("rd00_first/data_const", {24'd0, rd}, 32'hAA);
        fixed_lat = -1;

        run_access(1'b1, 8'h01, 8'h55, "wr01", rd, h);
        check("wr01/hit_const", {31'd0, h}, 32'd1);
        run_access(1'b0, 8'h01, 8'h00, "rd01", rd, h);
        check("rd01/data_const", {24'd0, rd}, 32'h55);

        run_access(1'b0, 8'h10, 8'h00, "rd10_fill_way1", rd, h);
        wb_base = wb_cnt;
        run_access(1'b0, 8'h20, 8'h00, "rd20_dirty_evict", rd, h);
        check("rd20/wb_happened", wb_cnt - wb_base, 32'd1);
        check("rd20/wb_addr_const", {26'd0, wb_addr}, 32'h00);
        check("rd20/wb_data_const", wb_data, 32'hDDCC55AA);
        check("rd20/fetch_addr_const", {26'd0, fetch_addr}, 32'h08);

`ifdef DCACHE_STATS_EN
        apply_reset();
        run_access(1'b0, 8'h00, 8'h00, "st_rd00", rd, h);
        run_access(1'b1, 8'h01, 8'h55, "st_wr01", rd, h);
        run_access(1'b0, 8'h01, 8'h00, "st_rd01", rd, h);
        check("stats/miss_count", {16'd0, miss_count}, 32'd1);
        check("stats/hit_count", {16'd0, hit_count}, 32'd2);
`endif

        apply_reset();
        wb_base = wb_cnt;
        run_access(1'b0, 8'h00, 8'h00, "cc_rd00", rd, h);
        run_access(1'b0, 8'h10, 8'h00, "cc_rd10", rd, h);
        run_access(1'b0, 8'h00, 8'h00, "cc_rd00_again", rd, h);
        run_access(1'b0, 8'h20, 8'h00, "cc_rd20", rd, h);
        run_access(1'b0, 8'h00, 8'h00, "cc_rd00_kept", rd, h);
        check("clean_conflict/no_wb", wb_cnt - wb_base, 32'd0);
        check("clean_conflict/rd00_hit", {31'd0, h}, 32'd1);

        apply_reset();
        fixed_lat = 6;
        @(negedge clock);
        read = 1'b1;
        cpu_address = 8'h00;
        n = 0;
        #1;
        while (mem_read !== 1'b1 && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("abort/fetch_started", {31'd0, mem_read}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        read = 1'b0;
        @(posedge clock);
        #1;
        check("abort/mem_read", {31'd0, mem_read}, 32'd0);
        check("abort/busywait", {31'd0, busywait}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        fixed_lat = -1;
        run_access(1'b0, 8'h00, 8'h00, "abort_rd00", rd, h);
        check("abort/rd00_misses", {31'd0, h}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            addr = {2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clock);
                @(negedge clock);
            end
            run_access(wr, addr, 8'($urandom), "rand", rd, h);
        end

`ifdef DCACHE_STATS_EN
        check("stats_rand/hit_count", {16'd0, hit_count}, m_hits);
        check("stats_rand/miss_count", {16'd0, miss_count}, m_misses);
`endif
        check("strobes/never_both", both_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/assoc_dcache.md
ASSOC_DCACHE -- requirements
Module: assoc_dcache

Interface
REQ-001 Parameter: ADDR_W, 8, CPU byte-address width.
REQ-002 Parameter: SET_BITS, 2, log2 of set count; tag width TAG_W = ADDR_W-2-SET_BITS.
REQ-003 Port: clock  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: read, write  input  1 each  CPU access strobes, held until busywait low.
REQ-006 Port: cpu_address  input  ADDR_W  byte address; [1:0] offset, [SET_BITS+1:2] set, upper bits tag.
REQ-007 Port: cpu_writeData  input  8  / cpu_readData  output  8  / busywait  output  1.
REQ-008 Port: mem_read, mem_write  output  1  / mem_address  output  ADDR_W-2  block address.
REQ-009 Port: mem_writeData  output  32  / mem_readData  input  32  / mem_busywait  input  1.

Function
REQ-010 SHALL be 2-way set-associative, write-back, write-allocate, 4-byte blocks, one LRU bit per set.
REQ-011 SHALL hit when either way of the set is valid with matching tag; hit data on cpu_readData combinationally, busywait 0, same cycle.
REQ-012 Write hit SHALL update the addressed byte at the next posedge and set that way's dirty bit.
REQ-013 Every hit and every fill SHALL set lru[set] to the other way.
REQ-014 Miss victim SHALL be the first invalid way (way 0 first), else way lru[set].
REQ-015 States SHALL be IDLE, WRITEBACK, FETCH, UPDATE.
REQ-016 IDLE: miss with dirty victim -> WRITEBACK; clean victim -> FETCH; else stay.
REQ-017 busywait SHALL be 1 combinationally on an IDLE miss and throughout WRITEBACK, FETCH, UPDATE.
REQ-018 WRITEBACK: mem_write=1, mem_address={victim tag, set}, mem_writeData=victim block; -> FETCH on the posedge with mem_busywait=0.
REQ-019 FETCH: mem_read=1, mem_address={tag, set}; -> UPDATE on the posedge with mem_busywait=0, capturing mem_readData.
REQ-020 UPDATE: write block, tag, valid=1, dirty=0 into victim; -> IDLE; the held access then completes as a hit.
REQ-021 mem_read, mem_write SHALL be 0 in IDLE and UPDATE; never both 1.
REQ-022 read and write both high SHALL be treated as write.
REQ-023 No access (read=write=0) SHALL leave all state unchanged.

Reset
REQ-024 reset at a posedge SHALL force IDLE and clear all valid, dirty, and LRU bits; the cycle after, busywait, mem_read, mem_write SHALL be 0.
REQ-025 reset mid-WRITEBACK/FETCH SHALL abort the transfer; no cache line is updated.
REQ-026 Data and tag arrays need not be reset.

Configuration
REQ-027 Macro DCACHE_STATS_EN defined: outputs hit_count, miss_count (16 bits each) added.
REQ-028 miss_count SHALL increment on each IDLE->WRITEBACK/FETCH transition.
REQ-029 hit_count SHALL increment on each access hitting on first lookup; post-refill completion SHALL not count.
REQ-030 Both counters SHALL saturate at 0xFFFF and reset to 0.
REQ-031 Macro undefined: the ports and counters are absent; all other behaviour is identical.

Verification
REQ-032 After reset, read 0x00; memory returns 0xDDCCBBAA after 3 busy cycles -> mem_read with mem_address 0x00, then cpu_readData=0xAA, busywait 0.
REQ-033 Then write 0x55 to 0x01, read 0x01 -> no mem strobes, cpu_readData=0x55.
REQ-034 Then read 0x10 (fill way 1), read 0x20 -> WRITEBACK mem_address 0x00 data 0xDDCC55AA, then FETCH mem_address 0x08.
REQ-035 Clean conflict: fill 0x00, 0x10, re-read 0x00, read 0x20 -> way holding tag 1 evicted, no mem_write, read 0x00 still hits.
REQ-036 reset during FETCH -> next cycle mem_read=0, busywait=0; read 0x00 misses again.
REQ-037 DCACHE_STATS_EN, sequence REQ-032..033 -> miss_count=1, hit_count=2.
